gray_sync_counter: RTL
======================

Name: gray_sync_counter

Overview:
- Parametrised up/down wrapping counter in the clk_src domain.
- Its value is carried to the clk_dst domain through an in-house Gray-code synchronizer; no vendor CDC macros are used.
- Successor to the fixed 2-bit counter-plus-Gray-CDC block: adds configurable width, sync depth and output register, count direction, source wrap flag, and destination valid/change flags.
- Used wherever a free-running event or position count must be observed from another clock domain.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- SYNC_STAGES, 3, number of destination synchronizer flops; legal range 2..6.
- REG_OUTPUT, 0, 1 adds one clk_dst register after Gray-to-binary decode.
- INIT_VAL, 0, counter value after reset; same value appears at dst_count after reset.

Ports:
- clk_src  in  1  source clock.
- clk_dst  in  1  destination clock.
- rst  in  1  reset: synchronous, active-high.
- en  in  1  clk_src; count step enable.
- dir  in  1  clk_src; 1 = up, 0 = down.
- src_count  out  WIDTH  clk_src; current binary count.
- src_wrap  out  1  clk_src; one-cycle pulse on wrap (up MAX->0 or down 0->MAX).
- dst_count  out  WIDTH  clk_dst; synchronized binary count.
- dst_valid  out  1  clk_dst; high once the synchronizer pipeline holds post-reset data.
- dst_changed  out  1  clk_dst; one-cycle pulse when dst_count differs from its previous value.

Behaviour:
- Reset:
  - rst is sampled synchronously in both domains.
  - The system holds rst high for at least SYNC_STAGES+2 cycles of the slower clock.
  - During reset: src_count = INIT_VAL, Gray register = gray(INIT_VAL), all sync flops = gray(INIT_VAL), dst_count = INIT_VAL, src_wrap = 0, dst_valid = 0, dst_changed = 0.
- Source counter (clk_src):
  - en=1, dir=1: count <= count+1 modulo 2^WIDTH.
  - en=1, dir=0: count <= count-1 modulo 2^WIDTH.
  - en=0: count holds.
  - Only one step per cycle; dir changes take effect on the same edge.
- src_wrap is registered and asserts in the cycle src_count shows the wrapped value (0 going up, 2^WIDTH-1 going down).
- Gray register (clk_src):
  - g_src <= bin2gray(next count), updated on the same edge as src_count.
  - bin2gray(b) = b ^ (b>>1).
  - g_src is the only signal crossing domains and is driven straight from a flop; no logic between the flop and the first sync stage.
- Since count moves by ±1 modulo 2^WIDTH per cycle, consecutive g_src values differ in exactly one bit, including at wrap and on direction reversal.
- Destination (clk_dst):
  - g_src passes through SYNC_STAGES flops in series.
  - The last stage is decoded with gray2bin (bit i = XOR of gray bits WIDTH-1..i).
  - REG_OUTPUT=0: decode drives dst_count combinationally from the last stage.
  - REG_OUTPUT=1: one extra flop.
- Latency: a g_src change stable before a clk_dst edge appears on dst_count after SYNC_STAGES clk_dst edges (+1 if REG_OUTPUT). One extra edge applies if the first sync flop resolves late.
- dst_valid:
  - A counter in the clk_dst domain, cleared by rst.
  - Asserts SYNC_STAGES+REG_OUTPUT clk_dst cycles after rst deasserts, then stays high until the next rst.
- dst_changed:
  - Compares dst_count against a registered previous copy; pulses for one clk_dst cycle per change.
  - Forced 0 while dst_valid=0.
- Sampling: if clk_src steps faster than clk_dst samples, dst_count skips intermediate values. Each observed value is still a real count value, never a mixed-bit value. No loss detection is provided.
- Reset mid-operation: count and all sync flops return to INIT_VAL on the first clock edge in each domain with rst=1. dst_valid drops immediately.
- Simultaneous en and rst: rst wins.

Test Plan:
- WIDTH=4, INIT_VAL=0, clk_src 100 MHz, clk_dst 37 MHz, en=1, dir=1 for 40 cycles → src_count 0..15, 0..; src_wrap pulses at src_count=0 (cycles 16, 32); dst_count always in 0..15 and non-decreasing modulo 16.
- Single step: en pulsed one cycle, dir=1, from 5 → src_count=6 next cycle; dst_count=6 exactly SYNC_STAGES(+REG_OUTPUT) clk_dst edges later; dst_changed one pulse.
- Down-count from 0 with dir=0 → src_count=15, src_wrap=1; dst_count later shows 15. Reverse dir at 3 → sequence 3,4,3,2; g_src Hamming distance 1 every step.
- Reset mid-count at src_count=9, INIT_VAL=2 → src_count=2, dst_count=2, dst_valid=0; dst_valid returns after SYNC_STAGES+REG_OUTPUT cycles; no dst_changed pulse during or after reset recovery.
- Fast clk_dst (250 MHz) vs clk_src 50 MHz, random en/dir, WIDTH=8 → dst_count equals src_count delayed, with no non-adjacent transitions; scoreboard matches every value.
- Parameter sweep SYNC_STAGES 2..4, REG_OUTPUT 0/1, WIDTH 2/8/16 → measured latency matches formula; all assertions (single-bit Gray change, valid timing) pass.

Source files
------------

// File: rtl/gray_sync_counter.sv
// gray_sync_counter: up/down wrapping counter in clk_src, carried to clk_dst
// through a Gray-coded multi-flop synchronizer with valid/changed flags.
module gray_sync_counter #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 3,
  parameter int REG_OUTPUT  = 0,
  parameter int INIT_VAL    = 0
) (
  input  logic             clk_src,
  input  logic             clk_dst,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] src_count,
  output logic             src_wrap,
  output logic [WIDTH-1:0] dst_count,
  output logic             dst_valid,
  output logic             dst_changed
);

  localparam logic [WIDTH-1:0] INIT  = INIT_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAXV  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] GINIT = INIT ^ (INIT >> 1);
  localparam int               VN    = SYNC_STAGES + ((REG_OUTPUT != 0) ? 1 : 0);
  localparam int               VW    = $clog2(VN + 1);
  localparam logic [VW-1:0]    VN_C  = VW'(VN);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------- source domain ----------------
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] g_src_q;
  logic             wrap_q;

  // Next count: one step per enabled cycle, direction applied on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = dir ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
  end

  // Count, Gray copy and wrap flag all register together so g_src never
  // passes through logic on its way to the first sync stage.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      cnt_q   <= INIT;
      g_src_q <= GINIT;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      g_src_q <= bin2gray(cnt_d);
      wrap_q  <= en & (dir ? (cnt_q == MAXV) : (cnt_q == '0));
    end
  end

  assign src_count = cnt_q;
  assign src_wrap  = wrap_q;

  // ---------------- destination domain ----------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  dec;
  logic [WIDTH-1:0]                  prev_q;
  logic [VW-1:0]                     vcnt_q, vcnt_d;
  logic                              valid_q;

  // Synchronizer chain; reset loads gray(INIT) so the decode is INIT at once.
  always_ff @(posedge clk_dst) begin
    if (rst) sync_q <= {SYNC_STAGES{GINIT}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], g_src_q};
  end

  assign dec = gray2bin(sync_q[SYNC_STAGES-1]);

  if (REG_OUTPUT != 0) begin : g_oreg
    logic [WIDTH-1:0] out_q;
    // Optional retiming flop after the decode.
    always_ff @(posedge clk_dst) begin
      if (rst) out_q <= INIT;
      else     out_q <= dec;
    end
    assign dst_count = out_q;
  end else begin : g_ocomb
    assign dst_count = dec;
  end

  // Valid counter saturates once the pipeline has been refilled after reset.
  always_comb begin
    vcnt_d = vcnt_q;
    if (vcnt_q != VN_C) vcnt_d = vcnt_q + VW'(1);
  end

  // Valid flag and previous-value copy for change detection.
  always_ff @(posedge clk_dst) begin
    if (rst) begin
      vcnt_q  <= '0;
      valid_q <= 1'b0;
      prev_q  <= INIT;
    end else begin
      vcnt_q  <= vcnt_d;
      valid_q <= (vcnt_d == VN_C);
      prev_q  <= dst_count;
    end
  end

  assign dst_valid   = valid_q;
  assign dst_changed = valid_q & (dst_count != prev_q);

endmodule
